// File: rtl/seg_pkg.sv
// seg_pkg -- shared definitions for the multiplexed seven-segment scanner.
//   SEG_0..SEG_9 : active-low segment codes, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments dark
//   bcd_to_seg() : BCD nibble to segment code; values A..F map to SEG_BLANK
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// seg_decode -- combinational BCD to seven-segment decoder.
//   val   : 4-bit BCD value (A..F decode to blank)
//   blank : force all segments dark
//   seg   : active-low segment code {g,f,e,d,c,b,a}
module seg_decode (
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);
  import seg_pkg::*;

  always_comb begin
    seg = blank ? SEG_BLANK : bcd_to_seg(val);
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed seven-segment display scanner.
//   clk, rst : clock, synchronous active-high reset
//   en       : display enable (0 = all outputs off, scanning continues)
//   digits   : BCD value, nibble i drives digit i (NDIG-1 most significant)
//   dp       : decimal point per digit, 1 = lit
//   lz       : leading-zero suppression enable (sampled live)
//   load     : strobe that captures digits/dp into the shadow register
//   h        : active-low segments {g,f,e,d,c,b,a}
//   dp_n     : active-low decimal point
//   an       : active-low one-cold digit select
//   frame    : one-cycle pulse at each frame start
// New data is staged in a shadow register and only promoted to the
// displayed (active) copy at a frame start, so a frame never mixes values.
module seg_scan #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [4*NDIG-1:0] digits,
  input  logic [NDIG-1:0]   dp,
  input  logic              lz,
  input  logic              load,
  output logic [6:0]        h,
  output logic              dp_n,
  output logic [NDIG-1:0]   an,
  output logic              frame
);
  import seg_pkg::*;

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  // scan state
  logic [DW-1:0]     div_q;
  logic [IW-1:0]     idx_q;
  logic [4*NDIG-1:0] sh_dig;
  logic [NDIG-1:0]   sh_dp;
  logic [4*NDIG-1:0] act_dig;
  logic [NDIG-1:0]   act_dp;
  logic              pending;

  // stage 0: next-slot values, valid on the tick cycle
  logic              vld_p0;
  logic              fstart_p0;
  logic              commit_p0;
  logic [IW-1:0]     idx_p0;
  logic [4*NDIG-1:0] dig_p0;
  logic [NDIG-1:0]   dpv_p0;
  logic [3:0]        nib_p0;
  logic              dpbit_p0;
  logic              supp_p0;
  logic              run_p0;
  logic [NDIG-1:0]   sel_p0;
  logic [6:0]        seg_p0;

  // stage 1: registered outputs
  logic [6:0]        h_p1;
  logic              dpn_p1;
  logic [NDIG-1:0]   an_p1;
  logic              frame_p1;

  always_comb begin
    vld_p0    = (div_q == DIV_LAST);
    fstart_p0 = vld_p0 && (idx_q == IDX_LAST);
    commit_p0 = fstart_p0 && pending;
    idx_p0    = fstart_p0 ? '0 : idx_q + IW'(1);
    // Outputs must show the post-commit value, so look through the commit.
    dig_p0    = commit_p0 ? sh_dig : act_dig;
    dpv_p0    = commit_p0 ? sh_dp  : act_dp;

    nib_p0   = 4'd0;
    dpbit_p0 = 1'b0;
    sel_p0   = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_p0 == IW'(i)) begin
        nib_p0    = dig_p0[4*i +: 4];
        dpbit_p0  = dpv_p0[i];
        sel_p0[i] = 1'b0;
      end
    end

    // Walk down from the MSD; a digit is a leading zero only while every
    // nibble above and including it is zero. Digit 0 is never examined.
    supp_p0 = 1'b0;
    run_p0  = 1'b1;
    for (int i = NDIG - 1; i > 0; i--) begin
      run_p0 = run_p0 & (dig_p0[4*i +: 4] == 4'd0);
      if (idx_p0 == IW'(i)) begin
        supp_p0 = lz & run_p0;
      end
    end
  end

  seg_decode u_dec (
    .val   (nib_p0),
    .blank (supp_p0),
    .seg   (seg_p0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      idx_q <= IDX_LAST;
    end else begin
      div_q <= vld_p0 ? '0 : div_q + DW'(1);
      if (vld_p0) begin
        idx_q <= idx_p0;
      end
    end
  end

  // A load coincident with a commit lands in the shadow while the commit
  // takes the older shadow contents, so pending must stay set.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_dig  <= '0;
      sh_dp   <= '0;
      act_dig <= '0;
      act_dp  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        sh_dig <= digits;
        sh_dp  <= dp;
      end
      if (commit_p0) begin
        act_dig <= sh_dig;
        act_dp  <= sh_dp;
      end
      if (load) begin
        pending <= 1'b1;
      end else if (commit_p0) begin
        pending <= 1'b0;
      end
    end
  end

  // stage 0 -> stage 1: output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_p1     <= SEG_BLANK;
      dpn_p1   <= 1'b1;
      an_p1    <= '1;
      frame_p1 <= 1'b0;
    end else begin
      frame_p1 <= fstart_p0;
      if (!en) begin
        h_p1   <= SEG_BLANK;
        dpn_p1 <= 1'b1;
        an_p1  <= '1;
      end else if (vld_p0) begin
        h_p1   <= seg_p0;
        dpn_p1 <= supp_p0 | ~dpbit_p0;
        an_p1  <= supp_p0 ? '1 : sel_p0;
      end
    end
  end

  assign h     = h_p1;
  assign dp_n  = dpn_p1;
  assign an    = an_p1;
  assign frame = frame_p1;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- directed self-checking bench for seg_scan (NDIG=4, DIV=4).
// Each digit slot lasts 4 clocks; a frame is 16 clocks.
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        lz;
  logic        load;
  logic [6:0]  h;
  logic        dp_n;
  logic [3:0]  an;
  logic        frame;

  int checks;
  int failures;

  seg_scan #(.NDIG(4), .DIV(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .digits (digits),
    .dp     (dp),
    .lz     (lz),
    .load   (load),
    .h      (h),
    .dp_n   (dp_n),
    .an     (an),
    .frame  (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input logic [3:0] an_e,
                          input logic [6:0] h_e, input logic dpn_e);
    chk({tag, ".an"},   {12'd0, an},  {12'd0, an_e});
    chk({tag, ".h"},    {9'd0, h},    {9'd0, h_e});
    chk({tag, ".dp_n"}, {15'd0, dp_n}, {15'd0, dpn_e});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b1;
    lz       = 1'b0;
    load     = 1'b0;
    digits   = 16'h0000;
    dp       = 4'b0000;

    // Reset state and first tick
    step(2);
    chk_slot("rst", 4'b1111, 7'b1111111, 1'b1);
    chk("rst.frame", {15'd0, frame}, 16'd0);
    rst = 1'b0;
    step(3);
    chk("idle.an", {12'd0, an}, 16'b1111);
    step(1);
    chk_slot("first", 4'b1110, 7'b1000000, 1'b1);
    chk("first.frame", {15'd0, frame}, 16'd1);
    step(1);
    chk("first.frame_end", {15'd0, frame}, 16'd0);

    // Load 1234 before first tick
    do_reset();
    digits = 16'h1234;
    dp     = 4'b0100;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk_slot("f1.d0", 4'b1110, 7'b0011001, 1'b1);
    chk("f1.frame", {15'd0, frame}, 16'd1);
    step(3);
    chk("f1.d0_hold", {12'd0, an}, 16'b1110);
    step(1);
    chk_slot("f1.d1", 4'b1101, 7'b0110000, 1'b1);
    step(4);
    chk_slot("f1.d2", 4'b1011, 7'b0100100, 1'b0);
    step(4);
    chk_slot("f1.d3", 4'b0111, 7'b1111001, 1'b1);
    step(4);
    chk_slot("f2.d0", 4'b1110, 7'b0011001, 1'b1);
    chk("f2.frame", {15'd0, frame}, 16'd1);

    // Mid-frame load of 0070 with lz: no tearing, then suppression
    digits = 16'h0070;
    dp     = 4'b0000;
    lz     = 1'b1;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk_slot("f2.d1", 4'b1101, 7'b0110000, 1'b1);
    step(4);
    chk_slot("f2.d2", 4'b1011, 7'b0100100, 1'b0);
    step(4);
    chk_slot("f2.d3", 4'b0111, 7'b1111001, 1'b1);
    step(4);
    chk_slot("lz70.d0", 4'b1110, 7'b1000000, 1'b1);
    step(4);
    chk_slot("lz70.d1", 4'b1101, 7'b1111000, 1'b1);
    step(4);
    chk_slot("lz70.d2", 4'b1111, 7'b1111111, 1'b1);
    step(4);
    chk_slot("lz70.d3", 4'b1111, 7'b1111111, 1'b1);
    step(4);
    chk_slot("lz70.d0b", 4'b1110, 7'b1000000, 1'b1);

    // All zeros with lz: only digit 0 lit
    digits = 16'h0000;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk_slot("lz70.d1b", 4'b1101, 7'b1111000, 1'b1);
    step(12);
    chk_slot("lz00.d0", 4'b1110, 7'b1000000, 1'b1);
    step(4);
    chk_slot("lz00.d1", 4'b1111, 7'b1111111, 1'b1);
    step(8);
    chk_slot("lz00.d3", 4'b1111, 7'b1111111, 1'b1);
    step(4);

    // Nibble A on digit 2 is blanked but selected
    lz     = 1'b0;
    digits = 16'h1A34;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(15);
    chk_slot("hexA.d0", 4'b1110, 7'b0011001, 1'b1);
    step(8);
    chk_slot("hexA.d2", 4'b1011, 7'b1111111, 1'b1);
    step(8);

    // Mid-frame load 5678, then a load coincident with the frame start
    digits = 16'h5678;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(3);
    chk_slot("mid.d1", 4'b1101, 7'b0110000, 1'b1);
    step(11);
    digits = 16'h9012;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    chk_slot("coin.d0", 4'b1110, 7'b0000000, 1'b1);
    chk("coin.frame", {15'd0, frame}, 16'd1);
    step(4);
    chk_slot("coin.d1", 4'b1101, 7'b1111000, 1'b1);
    step(12);
    chk_slot("late.d0", 4'b1110, 7'b0100100, 1'b1);
    step(4);
    chk_slot("late.d1", 4'b1101, 7'b1111001, 1'b1);

    // Reset mid-frame with pending data
    digits = 16'h3333;
    load   = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    chk_slot("midrst", 4'b1111, 7'b1111111, 1'b1);
    chk("midrst.frame", {15'd0, frame}, 16'd0);
    rst = 1'b0;
    step(4);
    chk_slot("post.d0", 4'b1110, 7'b1000000, 1'b1);
    chk("post.frame", {15'd0, frame}, 16'd1);
    step(4);
    chk_slot("post.d1", 4'b1101, 7'b1000000, 1'b1);

    // Display disabled: outputs off, scan continues
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("en0.an", {12'd0, an}, 16'b1111);
    end
    chk("en0.idx", {14'd0, dut.idx_q}, 16'd3);
    en = 1'b1;
    step(1);
    chk("en1.wait", {12'd0, an}, 16'b1111);
    step(1);
    chk_slot("en1.d0", 4'b1110, 7'b1000000, 1'b1);
    chk("en1.frame", {15'd0, frame}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter NDIG, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot; legal range 2 and above.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  display enable; 0 forces all outputs to the off state.
REQ-006 digits  input  4*NDIG  BCD value; nibble i is digit i, with digit NDIG-1 most significant.
REQ-007 dp  input  NDIG  decimal point per digit, 1 = lit.
REQ-008 lz  input  1  leading-zero suppression enable.
REQ-009 load  input  1  single-cycle strobe that captures digits and dp into the shadow register.
REQ-010 h  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 dp_n  output  1  active-low decimal point.
REQ-012 an  output  NDIG  active-low digit select, one-cold.
REQ-013 frame  output  1  one-cycle pulse at each frame start.

Function
REQ-014 Divider: counts 0..DIV-1 and wraps; tick is asserted in the cycle where the divider equals DIV-1.
REQ-015 On tick, digit index idx advances by 1 and wraps from NDIG-1 to 0; a wrap to 0 is a frame start.
REQ-016 Shadow path: load writes shadow digits and dp and sets pending; a load while pending is set overwrites the shadow, last write wins.
REQ-017 At a frame start with pending=1, active <= shadow value held before that edge, and pending clears.
REQ-018 If load coincides with a frame start, the commit uses the old shadow; the new data is stored in the shadow and pending remains 1.
REQ-019 Displayed data changes only at frame starts (no tearing), including when load arrives mid-frame.
REQ-020 frame pulses high for one cycle on every frame start, whether or not pending was set.
REQ-021 h, dp_n and an are registered and update on the tick edge, showing the new idx and the post-commit active value.
REQ-022 Decode map: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 A nibble value of A..F is blanked: h=1111111 and the an bit stays asserted.
REQ-024 Leading-zero rule: with lz=1, digit i (i>0) is suppressed when all active nibbles from NDIG-1 down to i are 0.
REQ-025 A suppressed digit drives h=1111111, dp_n=1 and an=all 1; digit 0 is never suppressed.
REQ-026 dp_n equals the inverse of active dp[idx] for non-suppressed digits.
REQ-027 With en=0: h=1111111, dp_n=1, an=all 1; the divider, idx, shadow and commit logic continue to run.
REQ-028 When en rises, outputs resume at the next tick edge.
REQ-029 lz and en are sampled live, not shadowed.

Reset
REQ-030 On rst, the following values load: divider=0, idx=NDIG-1, shadow=0, active=0, pending=0, h=1111111, dp_n=1, an=all 1, frame=0.
REQ-031 The first tick after reset release is a frame start, showing digit 0.
REQ-032 rst asserted mid-scan or mid-pending discards the pending data and returns all state to the REQ-030 values on that edge.

Structure
REQ-033 Package seg_pkg holds the segment code constants, SEG_BLANK=1111111, and the BCD-to-segment decode function.
REQ-034 One sub-module, seg_decode, is used: 4-bit value plus blank flag in, 7-bit active-low code out, purely combinational.
REQ-035 The divider, idx, shadow/commit and output registers reside in seg_scan.

Verification (NDIG=4, DIV=4)
REQ-036 Reset, then 4 idle cycles -> outputs off until the first tick on the 4th edge; frame pulses; an=1110, h=1000000.
REQ-037 load digits=16'h1234, dp=4'b0100 before the first tick -> slots show an=1110 h=0011001 dp_n=1; an=1101 h=0110000; an=1011 h=0100100 dp_n=0; an=0111 h=1111001; each slot lasts 4 cycles.
REQ-038 lz=1, digits=16'h0070 -> digits 3 and 2 show an=1111 h=1111111; digit 1 shows h=1111000; digit 0 shows h=1000000; digits=16'h0000 -> only digit 0 is lit with h=1000000.
REQ-039 Nibble 4'hA on digit 2 -> that slot shows h=1111111 with an=1011.
REQ-040 Mid-frame load 16'h5678 -> remaining slots keep the old value; the next frame shows 5678.
REQ-041 A load coincident with frame -> the old shadow is displayed and the new value appears one frame later.
REQ-042 rst pulse mid-frame with pending=1 -> all outputs off next cycle; after restart, 0000 is shown.
REQ-043 en=0 for 10 cycles -> an=1111 throughout; a scope check shows idx still advancing.
